ttt_turn_controller: RTL and testbench
======================================

# ttt_turn_controller

Turn sequencer for the tic-tac-toe datapath. It owns the game flow:
- clears the board-state block at game start;
- alternates X and O;
- validates each player's tile request against the current board;
- issues single-cycle move commands;
- confirms the board updated, then decides win/draw/continue.

It sits between the player input logic (debounced pulses) and the board-state block, and is the only driver of that block's move/clear controls.

## Interface
- TURN_TIMEOUT, 1000000: cycles a player may idle in TURN before forfeiting the turn; 0 disables.
- ACK_TIMEOUT, 8: max cycles in WAIT_ACK before declaring a fault.
- FIRST_PLAYER, 1: player to move first after every start (1 = X, 0 = O).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begin a new game (legal in any state).
- move_req  in  1  one-cycle pulse; current player requests a move.
- req_tile  in  4  tile requested, 1..9; tile n maps to board bit 9-n.
- x_board  in  9  X occupancy from the board-state block.
- o_board  in  9  O occupancy from the board-state block.
- gs_clear  out  1  one-cycle clear pulse to the board-state block.
- gs_move  out  1  one-cycle move strobe to the board-state block.
- gs_player  out  1  mover for gs_move (1 = X).
- gs_tile  out  4  tile for gs_move.
- turn  out  1  player currently to move.
- busy  out  1  high in CLEAR, ISSUE, WAIT_ACK, EVAL.
- req_err  out  1  one-cycle pulse: request rejected.
- forfeit  out  1  one-cycle pulse: turn timed out.
- fault  out  1  sticky; board did not acknowledge, or X/O overlap.
- result  out  2  00 in progress, 01 X won, 10 O won, 11 draw.
- move_count  out  4  accepted moves this game, 0..9.

## Operation
- **States:** IDLE, CLEAR, TURN, ISSUE, WAIT_ACK, EVAL, OVER, FAULT.
- **Reset values:** state IDLE; turn = FIRST_PLAYER; every other output 0.
- **start, from any state:** next state CLEAR, with gs_clear=1 for exactly that cycle. In the same transition:
  - result, move_count, fault, turn-timer cleared;
  - turn = FIRST_PLAYER.
- **start priority:** start wins over move_req and over every other transition in the same cycle.
- **CLEAR → TURN:** unconditional, one cycle.
- **TURN, on move_req:** the request is legal when req_tile is in 1..9 and bit 9-req_tile is 0 in both x_board and o_board.
  - Legal: latch gs_player=turn and gs_tile=req_tile; go to ISSUE.
  - Illegal: req_err=1 for one cycle; stay in TURN; turn-timer unchanged.
- **move_req outside TURN:** ignored; no req_err.
- **Turn-timer:** counts cycles in TURN and resets on entering TURN. When it reaches TURN_TIMEOUT:
  - forfeit=1 for one cycle;
  - turn toggles;
  - timer restarts;
  - state stays TURN;
  - move_count is unchanged.
- **ISSUE:** gs_move=1 for exactly one cycle; then WAIT_ACK.
- **WAIT_ACK:** watch the target bit in the mover's board.
  - Bit seen set: move_count += 1, then EVAL.
  - ACK_TIMEOUT cycles elapse without it: go to FAULT.
- **EVAL:** evaluated on the current boards.
  - Lines: 111000000, 000111000, 000000111, 100100100, 010010010, 001001001, 100010001, 001010100.
  - Evaluation order:
    1. (x_board & o_board) != 0 → FAULT.
    2. X holds all bits of any line → result 01, OVER.
    3. O holds all bits of any line → result 10, OVER.
    4. (x_board | o_board) == 9'h1FF → result 11, OVER.
    5. Otherwise toggle turn → TURN.
- **OVER:** result is held; move_req ignored; leave only on start.
- **FAULT:** fault=1; gs_move never asserted; leave only on start.
- **Output encoding:** gs_tile and gs_player hold their last value outside ISSUE. Only gs_move and gs_clear are strobes.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- **Start latency:** start at cycle t → gs_clear high at t+1 → TURN at t+2 with busy=0.
- **Move latency:** legal move_req at t →
  - gs_move at t+1;
  - WAIT_ACK from t+2;
  - the board block updates at t+2, so the ack is seen at t+2;
  - EVAL at t+3;
  - turn toggles and TURN is re-entered at t+4.
- **req_err:** asserted the cycle after the illegal request.
- **forfeit:** asserted the cycle after the timer reaches TURN_TIMEOUT.
- **Back-to-back requests:** the earliest next request is accepted in the first TURN cycle.
- **Reset:** rst mid-operation, including mid-strobe, returns to IDLE immediately; a strobe is never extended.

## Test plan
- **Reset then start:** gs_clear pulses once at t+1, turn=1, result=00, move_count=0.
- **X wins row 1:**
  - move sequence: X1, O4, X2, O5, X3;
  - expect five gs_move pulses with alternating gs_player;
  - result=01 after the third X move; move_count=5; later move_req ignored.
- **Illegal requests:**
  - req_tile=0, 10, and an already-occupied tile each give req_err=1 for one cycle;
  - no gs_move; turn unchanged.
- **Draw:**
  - sequence X1 O2 X3 O5 X4 O6 X8 O7 X9;
  - expect result=11, move_count=9.
- **Turn timeout:**
  - TURN_TIMEOUT=20, no requests;
  - forfeit at cycle 21 of TURN, turn toggles; repeats every 20 cycles.
- **Fault path:**
  - board model ignores gs_move: FAULT after ACK_TIMEOUT cycles, fault=1;
  - separately, force X/O overlap: FAULT at EVAL.
  - In both cases start clears fault and the next game proceeds normally.

Source files
------------

// File: rtl/ttt_turn_controller.sv
// ttt_turn_controller
//
// Game-flow sequencer for the tic-tac-toe datapath. It clears the board-state
// block at game start, alternates X and O, validates each tile request against
// the current boards, issues single-cycle move commands, waits for the board
// to show the new mark, then decides win / draw / continue.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   start        1-cycle pulse: begin a new game (accepted in any state)
//   move_req     1-cycle pulse: current player requests req_tile
//   req_tile     requested tile 1..9 (tile n <-> board bit 9-n)
//   x_board      X occupancy from the board-state block
//   o_board      O occupancy from the board-state block
//   gs_clear     1-cycle clear strobe to the board-state block
//   gs_move      1-cycle move strobe to the board-state block
//   gs_player    mover for gs_move (1 = X); holds last value
//   gs_tile      tile for gs_move; holds last value
//   turn         player currently to move (1 = X)
//   busy         high in CLEAR, ISSUE, WAIT_ACK, EVAL
//   req_err      1-cycle pulse: request rejected
//   forfeit      1-cycle pulse: turn timed out
//   fault        sticky until start: missing ack or X/O overlap
//   result       00 in progress, 01 X won, 10 O won, 11 draw
//   move_count   accepted moves this game, 0..9
//
// Every output is a register; the combinational process only computes the
// next value of each one.

module ttt_turn_controller #(
   parameter int unsigned TURN_TIMEOUT = 1000000, // 0 disables forfeits
   parameter int unsigned ACK_TIMEOUT  = 8,
   parameter bit          FIRST_PLAYER = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_req,
   input  logic [3:0] req_tile,
   input  logic [8:0] x_board,
   input  logic [8:0] o_board,
   output logic       gs_clear,
   output logic       gs_move,
   output logic       gs_player,
   output logic [3:0] gs_tile,
   output logic       turn,
   output logic       busy,
   output logic       req_err,
   output logic       forfeit,
   output logic       fault,
   output logic [1:0] result,
   output logic [3:0] move_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_TURN, S_ISSUE, S_WAIT_ACK, S_EVAL, S_OVER, S_FAULT
   } state_t;

   localparam logic [8:0] LINES [8] = '{
      9'b111000000, 9'b000111000, 9'b000000111, 9'b100100100,
      9'b010010010, 9'b001001001, 9'b100010001, 9'b001010100
   };

   // One-hot board bit for a tile; zero for tiles outside 1..9.
   function automatic logic [8:0] tile_mask(input logic [3:0] tile);
      logic [8:0] m;
      m = '0;
      if (tile >= 4'd1 && tile <= 4'd9) m = 9'h100 >> (tile - 4'd1);
      return m;
   endfunction

   function automatic logic has_line(input logic [8:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((b & LINES[i]) == LINES[i]) hit = 1'b1;
      return hit;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] timer_q, timer_d;     // completed cycles of the current turn
   logic [31:0] ack_cnt_q, ack_cnt_d; // cycles spent in WAIT_ACK
   logic        turn_d, gs_player_d, gs_clear_d, gs_move_d;
   logic        req_err_d, forfeit_d, busy_d, fault_d;
   logic [3:0]  gs_tile_d, move_count_d;
   logic [1:0]  result_d;

   logic [8:0] req_mask;
   logic       req_legal;
   logic       ack_seen;

   assign req_mask  = tile_mask(req_tile);
   assign req_legal = (|req_mask) && !(|(req_mask & (x_board | o_board)));
   assign ack_seen  = |(tile_mask(gs_tile) & (gs_player ? x_board : o_board));

   // NOTE: every variable gets its default before any branch, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      ack_cnt_d    = ack_cnt_q;
      turn_d       = turn;
      gs_player_d  = gs_player;
      gs_tile_d    = gs_tile;
      result_d     = result;
      move_count_d = move_count;
      gs_clear_d   = 1'b0;
      gs_move_d    = 1'b0;
      req_err_d    = 1'b0;
      forfeit_d    = 1'b0;

      if (start) begin
         // start overrides whatever the current state would have done
         state_d      = S_CLEAR;
         gs_clear_d   = 1'b1;
         turn_d       = FIRST_PLAYER;
         timer_d      = '0;
         ack_cnt_d    = '0;
         result_d     = 2'b00;
         move_count_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
               state_d = S_TURN;
               timer_d = '0;
            end
            S_TURN: begin
               if (move_req && req_legal) begin
                  gs_player_d = turn;
                  gs_tile_d   = req_tile;
                  gs_move_d   = 1'b1;
                  state_d     = S_ISSUE;
               end else begin
                  // a rejected request neither resets nor pauses the timer
                  req_err_d = move_req;
                  if (TURN_TIMEOUT != 0 && timer_q + 32'd1 >= TURN_TIMEOUT) begin
                     forfeit_d = 1'b1;
                     turn_d    = ~turn;
                     timer_d   = '0;
                  end else begin
                     timer_d = timer_q + 32'd1;
                  end
               end
            end
            S_ISSUE: begin
               state_d   = S_WAIT_ACK;
               ack_cnt_d = '0;
            end
            S_WAIT_ACK: begin
               if (ack_seen) begin
                  move_count_d = move_count + 4'd1;
                  state_d      = S_EVAL;
               end else if (ack_cnt_q + 32'd1 >= ACK_TIMEOUT) begin
                  state_d = S_FAULT;
               end else begin
                  ack_cnt_d = ack_cnt_q + 32'd1;
               end
            end
            S_EVAL: begin
               if ((x_board & o_board) != 9'd0) begin
                  state_d = S_FAULT;
               end else if (has_line(x_board)) begin
                  result_d = 2'b01;
                  state_d  = S_OVER;
               end else if (has_line(o_board)) begin
                  result_d = 2'b10;
                  state_d  = S_OVER;
               end else if ((x_board | o_board) == 9'h1FF) begin
                  result_d = 2'b11;
                  state_d  = S_OVER;
               end else begin
                  turn_d  = ~turn;
                  timer_d = '0;
                  state_d = S_TURN;
               end
            end
            S_OVER:  ;
            S_FAULT: ;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d  = (state_d == S_CLEAR) || (state_d == S_ISSUE) ||
                (state_d == S_WAIT_ACK) || (state_d == S_EVAL);
      fault_d = (state_d == S_FAULT);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values computed above, independent of ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         ack_cnt_q  <= '0;
         turn       <= FIRST_PLAYER;
         gs_player  <= 1'b0;
         gs_tile    <= '0;
         result     <= 2'b00;
         move_count <= '0;
         gs_clear   <= 1'b0;
         gs_move    <= 1'b0;
         req_err    <= 1'b0;
         forfeit    <= 1'b0;
         busy       <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         ack_cnt_q  <= ack_cnt_d;
         turn       <= turn_d;
         gs_player  <= gs_player_d;
         gs_tile    <= gs_tile_d;
         result     <= result_d;
         move_count <= move_count_d;
         gs_clear   <= gs_clear_d;
         gs_move    <= gs_move_d;
         req_err    <= req_err_d;
         forfeit    <= forfeit_d;
         busy       <= busy_d;
         fault      <= fault_d;
      end
   end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Testbench for ttt_turn_controller. A small board-state model answers the
// DUT's clear/move strobes. Every strobe the DUT emits (gs_clear, gs_move,
// req_err, forfeit) is matched against a queue of expected events pushed when
// the stimulus is driven; state outputs are checked at fixed cycle offsets.

module tb_ttt_turn_controller;

   localparam int TURN_TO = 20;
   localparam int ACK_TO  = 8;

   localparam int EV_CLEAR   = 1;
   localparam int EV_MOVE    = 2;
   localparam int EV_ERR     = 3;
   localparam int EV_FORFEIT = 4;

   logic       clk = 1'b0;
   logic       rst, start, move_req;
   logic [3:0] req_tile;
   logic [8:0] x_board, o_board;
   logic       gs_clear, gs_move, gs_player, turn, busy, req_err, forfeit, fault;
   logic [3:0] gs_tile, move_count;
   logic [1:0] result;

   logic ignore_move;    // board model drops gs_move
   logic inject_overlap; // board model marks both boards on gs_move

   int n_cmp = 0;
   int n_err = 0;
   int exp_q[$];
   int exp_turn;
   int exp_moves;

   ttt_turn_controller #(
      .TURN_TIMEOUT(TURN_TO),
      .ACK_TIMEOUT (ACK_TO),
      .FIRST_PLAYER(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .move_req  (move_req),
      .req_tile  (req_tile),
      .x_board   (x_board),
      .o_board   (o_board),
      .gs_clear  (gs_clear),
      .gs_move   (gs_move),
      .gs_player (gs_player),
      .gs_tile   (gs_tile),
      .turn      (turn),
      .busy      (busy),
      .req_err   (req_err),
      .forfeit   (forfeit),
      .fault     (fault),
      .result    (result),
      .move_count(move_count)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] bit_of(input int n);
      logic [8:0] m;
      m = '0;
      m[9 - n] = 1'b1;
      return m;
   endfunction

   // Board-state model: updates on the edge after the strobe.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         x_board <= '0;
         o_board <= '0;
      end else if (gs_clear) begin
         x_board <= '0;
         o_board <= '0;
      end else if (gs_move && !ignore_move) begin
         if (gs_player || inject_overlap) x_board <= x_board | bit_of(int'(gs_tile));
         if (!gs_player || inject_overlap) o_board <= o_board | bit_of(int'(gs_tile));
      end
   end

   function automatic int ev(input int kind, input int pl, input int tile);
      return kind * 256 + pl * 16 + tile;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic observe(input string tag, input int got);
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(got), 32'd0);
      else check(tag, 32'(got), 32'(exp_q.pop_front()));
   endtask

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (gs_clear) observe("gs_clear", ev(EV_CLEAR, 0, 0));
         if (gs_move)  observe("gs_move", ev(EV_MOVE, int'(gs_player), int'(gs_tile)));
         if (req_err)  observe("req_err", ev(EV_ERR, 0, 0));
         if (forfeit)  observe("forfeit", ev(EV_FORFEIT, 0, 0));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      exp_q.push_back(ev(EV_CLEAR, 0, 0));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy_clear", 32'(busy), 32'd1);
      tick();
      exp_turn  = 1;
      exp_moves = 0;
      check("start_busy_turn", 32'(busy), 32'd0);
      check("start_turn", 32'(turn), 32'd1);
      check("start_result", 32'(result), 32'd0);
      check("start_count", 32'(move_count), 32'd0);
      check("start_fault", 32'(fault), 32'd0);
   endtask

   // Legal move; outcome 0 = continue, else expected final result code.
   task automatic play(input int tile, input int outcome);
      exp_q.push_back(ev(EV_MOVE, exp_turn, tile));
      move_req = 1'b1;
      req_tile = 4'(tile);
      tick();
      move_req = 1'b0;
      check("move_busy", 32'(busy), 32'd1);
      tick(3);
      exp_moves++;
      check("move_count", 32'(move_count), 32'(exp_moves));
      check("move_busy_done", 32'(busy), 32'd0);
      check("move_result", 32'(result), 32'(outcome));
      if (outcome == 0) begin
         exp_turn ^= 1;
         check("move_turn", 32'(turn), 32'(exp_turn));
      end
   endtask

   task automatic bad_req(input int tile);
      exp_q.push_back(ev(EV_ERR, 0, 0));
      move_req = 1'b1;
      req_tile = 4'(tile);
      tick();
      move_req = 1'b0;
      check("bad_turn", 32'(turn), 32'(exp_turn));
      check("bad_busy", 32'(busy), 32'd0);
      tick();
      check("bad_err_one_cycle", 32'(req_err), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; move_req = 1'b0; req_tile = '0;
      ignore_move = 1'b0; inject_overlap = 1'b0;
      exp_turn = 1; exp_moves = 0;
      tick(2);
      check("rst_turn", 32'(turn), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_count", 32'(move_count), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_strobes", 32'({gs_clear, gs_move, req_err, forfeit}), 32'd0);
      rst = 1'b0;
      tick();

      // reset asserted while gs_clear is high kills the strobe at once
      start = 1'b1;
      tick();
      start = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("midrst_clear", 32'(gs_clear), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick(2);
      check("midrst_idle", 32'({gs_clear, busy}), 32'd0);

      // X wins on row 1
      do_start();
      play(1, 0); play(4, 0); play(2, 0); play(5, 0); play(3, 1);
      move_req = 1'b1; req_tile = 4'd9;
      tick();
      move_req = 1'b0;
      tick(3);
      check("over_result", 32'(result), 32'd1);
      check("over_count", 32'(move_count), 32'd5);

      // illegal requests: out of range and occupied
      do_start();
      play(1, 0);
      bad_req(0); bad_req(10); bad_req(1);
      play(5, 0);

      // draw
      do_start();
      play(1, 0); play(2, 0); play(3, 0); play(5, 0); play(4, 0);
      play(6, 0); play(8, 0); play(7, 0); play(9, 3);

      // turn timeout: first TURN cycle is cycle 1
      do_start();
      exp_q.push_back(ev(EV_FORFEIT, 0, 0));
      exp_q.push_back(ev(EV_FORFEIT, 0, 0));
      tick(TURN_TO - 1);
      check("to_before1", 32'(forfeit), 32'd0);
      check("to_turn_before1", 32'(turn), 32'd1);
      tick();
      check("to_forfeit1", 32'(forfeit), 32'd1);
      check("to_turn1", 32'(turn), 32'd0);
      check("to_count1", 32'(move_count), 32'd0);
      tick(TURN_TO - 1);
      check("to_before2", 32'(forfeit), 32'd0);
      tick();
      check("to_forfeit2", 32'(forfeit), 32'd1);
      check("to_turn2", 32'(turn), 32'd1);

      // missing acknowledge
      ignore_move = 1'b1;
      do_start();
      exp_q.push_back(ev(EV_MOVE, 1, 5));
      move_req = 1'b1; req_tile = 4'd5;
      tick();
      move_req = 1'b0;
      tick(ACK_TO);
      check("ack_fault_early", 32'(fault), 32'd0);
      check("ack_busy_wait", 32'(busy), 32'd1);
      tick();
      check("ack_fault", 32'(fault), 32'd1);
      check("ack_busy_fault", 32'(busy), 32'd0);
      move_req = 1'b1; req_tile = 4'd7;
      tick();
      move_req = 1'b0;
      tick(2);
      check("ack_fault_sticky", 32'(fault), 32'd1);
      ignore_move = 1'b0;
      do_start();
      play(5, 0);

      // X/O overlap caught in EVAL
      inject_overlap = 1'b1;
      do_start();
      exp_q.push_back(ev(EV_MOVE, 1, 5));
      move_req = 1'b1; req_tile = 4'd5;
      tick();
      move_req = 1'b0;
      tick(3);
      check("ovl_fault", 32'(fault), 32'd1);
      check("ovl_count", 32'(move_count), 32'd1);
      check("ovl_result", 32'(result), 32'd0);
      inject_overlap = 1'b0;
      do_start();
      play(5, 0); play(1, 0);

      tick(2);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
